// File: rtl/message_decoder.sv
// rtl/message_decoder.sv - byte-stream decoder driving a four-voice note table and a program register
//
// Ports:
//   clk          sole clock, rising edge
//   rst          asynchronous active-high reset
//   data[7:0]    message byte, valid while mstart=1
//   mstart       sender strobe; byte taken on an edge with mstart=1 and mready=1
//   mready       registered; high only while idle and able to take a byte
//   voice_note   four 6-bit note numbers, voice v at [6v+5:6v]
//   voice_gate   bit v high while voice v holds a note
//   program_num  current program number
//   prog_strobe  one-cycle pulse on program change
//   retrig       one-cycle pulse when a note-on hits an already-gated note
//   overflow     one-cycle pulse when a note-on is dropped (held 0 with VOICE_STEAL_EN)
//
// Build option: define VOICE_STEAL_EN to overwrite a voice in round-robin order
// when a note-on finds the table full, instead of dropping it.

module message_decoder (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  data,
  input  logic        mstart,
  output logic        mready,
  output logic [23:0] voice_note,
  output logic [3:0]  voice_gate,
  output logic [6:0]  program_num,
  output logic        prog_strobe,
  output logic        retrig,
  output logic        overflow
);

  typedef enum logic [1:0] {IDLE, DECODE, SCAN, COMMIT} state_t;

  state_t      state;
  state_t      next_state;
  logic [7:0]  byte_q;
  logic [5:0]  notes [4];
  logic [1:0]  scan_idx;
  logic        match_found;
  logic [1:0]  match_idx;
  logic        free_found;
  logic [1:0]  free_idx;
  logic        accept;
  logic        hit;
  logic        vacant;

`ifdef VOICE_STEAL_EN
  logic [1:0]  steal_ptr;
`endif

  assign accept     = mstart && mready;
  assign voice_note = {notes[3], notes[2], notes[1], notes[0]};

  // Per-cycle examination of the voice selected by scan_idx.
  always_comb begin
    hit    = 1'b0;
    vacant = 1'b0;
    if (state == SCAN) begin
      hit    = voice_gate[scan_idx] && (notes[scan_idx] == byte_q[7:2]);
      vacant = !voice_gate[scan_idx];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = DECODE;
      DECODE:  next_state = byte_q[0] ? IDLE : SCAN;
      SCAN:    if (scan_idx == 2'd3) next_state = COMMIT;
      COMMIT:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mready      <= 1'b0;
      byte_q      <= 8'h00;
      scan_idx    <= 2'd0;
      match_found <= 1'b0;
      match_idx   <= 2'd0;
      free_found  <= 1'b0;
      free_idx    <= 2'd0;
      voice_gate  <= 4'b0000;
      program_num <= 7'd0;
      prog_strobe <= 1'b0;
      retrig      <= 1'b0;
      for (int v = 0; v < 4; v++) notes[v] <= 6'd0;
`ifdef VOICE_STEAL_EN
      steal_ptr   <= 2'd0;
`else
      overflow    <= 1'b0;
`endif
    end else begin
      // mready mirrors the state being entered, so it is high exactly in IDLE.
      mready      <= (next_state == IDLE);
      prog_strobe <= 1'b0;
      retrig      <= 1'b0;
`ifndef VOICE_STEAL_EN
      overflow    <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (accept) byte_q <= data;
        end
        DECODE: begin
          scan_idx    <= 2'd0;
          match_found <= 1'b0;
          free_found  <= 1'b0;
          if (byte_q[0]) begin
            program_num <= byte_q[7:1];
            prog_strobe <= 1'b1;
          end
        end
        SCAN: begin
          // First hit wins, so the recorded index is the lowest one.
          if (hit && !match_found) begin
            match_found <= 1'b1;
            match_idx   <= scan_idx;
          end
          if (vacant && !free_found) begin
            free_found <= 1'b1;
            free_idx   <= scan_idx;
          end
          scan_idx <= scan_idx + 2'd1;
        end
        COMMIT: begin
          if (byte_q[1]) begin
            if (match_found) begin
              retrig <= 1'b1;
            end else if (free_found) begin
              notes[free_idx]      <= byte_q[7:2];
              voice_gate[free_idx] <= 1'b1;
            end else begin
`ifdef VOICE_STEAL_EN
              // Stolen voice keeps its gate; only the note number changes.
              notes[steal_ptr] <= byte_q[7:2];
              steal_ptr        <= steal_ptr + 2'd1;
`else
              overflow <= 1'b1;
`endif
            end
          end else if (match_found) begin
            voice_gate[match_idx] <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef VOICE_STEAL_EN
  assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_message_decoder.sv
// tb/tb_message_decoder.sv - randomized self-checking bench for message_decoder

module tb_message_decoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  data = 8'h00;
  logic        mstart = 1'b0;
  logic        mready;
  logic [23:0] voice_note;
  logic [3:0]  voice_gate;
  logic [6:0]  program_num;
  logic        prog_strobe;
  logic        retrig;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  // Reference model: plain table of voices.
  int m_note [4];
  bit m_gate [4];
  int m_prog;
  int m_ptr;

  message_decoder dut (
    .clk(clk), .rst(rst), .data(data), .mstart(mstart), .mready(mready),
    .voice_note(voice_note), .voice_gate(voice_gate), .program_num(program_num),
    .prog_strobe(prog_strobe), .retrig(retrig), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] model_notes();
    logic [23:0] r = '0;
    for (int v = 0; v < 4; v++) r[6*v +: 6] = m_note[v][5:0];
    return r;
  endfunction

  function automatic logic [3:0] model_gates();
    logic [3:0] r = '0;
    for (int v = 0; v < 4; v++) r[v] = m_gate[v];
    return r;
  endfunction

  task automatic model_clear();
    for (int v = 0; v < 4; v++) begin
      m_note[v] = 0;
      m_gate[v] = 0;
    end
    m_prog = 0;
    m_ptr  = 0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_notes"}, voice_note, model_notes());
    check({tag, "_gates"}, voice_gate, model_gates());
    check({tag, "_prog"},  program_num, m_prog);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    mstart = 1'b0;
    @(posedge clk); #1;
    check("rst_mready", mready, 0);
    check("rst_pulses", {prog_strobe, retrig, overflow}, 0);
    model_clear();
    check_outputs("rst");
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    check("rst_release_mready", mready, 1);
  endtask

  // Sends one byte, follows it to completion and compares against the model.
  task automatic send(input logic [7:0] b, input bit hold);
    int w = 0;
    int lat = 0;
    int nps = 0, nrt = 0, nof = 0;
    int exp_lat, exp_ps = 0, exp_rt = 0, exp_of = 0;
    int mi = -1, fi = -1, n;
    while (!mready && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    check("ready_before_send", mready, 1);

    if (b[0]) begin
      m_prog  = b[7:1];
      exp_lat = 1;
      exp_ps  = 1;
    end else begin
      n = b[7:2];
      exp_lat = 6;
      for (int v = 3; v >= 0; v--) begin
        if (m_gate[v] && m_note[v] == n) mi = v;
        if (!m_gate[v]) fi = v;
      end
      if (b[1]) begin
        if (mi >= 0) exp_rt = 1;
        else if (fi >= 0) begin
          m_note[fi] = n;
          m_gate[fi] = 1;
        end else begin
`ifdef VOICE_STEAL_EN
          m_note[m_ptr] = n;
          m_ptr = (m_ptr + 1) % 4;
`else
          exp_of = 1;
`endif
        end
      end else if (mi >= 0) begin
        m_gate[mi] = 0;
      end
    end

    @(negedge clk);
    data = b;
    mstart = 1'b1;
    @(posedge clk); #1;
    check("accept_drops_mready", mready, 0);
    if (!hold) begin
      mstart = 1'b0;
      data = 8'($urandom);
    end
    while (!mready && lat < 12) begin
      @(posedge clk); #1;
      lat++;
      nps += int'(prog_strobe);
      nrt += int'(retrig);
      nof += int'(overflow);
    end
    mstart = 1'b0;
    check("latency", lat, exp_lat);
    check("prog_strobe_count", nps, exp_ps);
    check("retrig_count", nrt, exp_rt);
    check("overflow_count", nof, exp_of);
    check_outputs("msg");
    @(posedge clk); #1;
    check("pulses_clear", {prog_strobe, retrig, overflow}, 0);
    check_outputs("idle");
  endtask

  initial begin
    model_clear();
    do_reset();

    // Program change 5.
    send(8'h0B, 0);
    // Note-on 7, then note-off 7.
    send(8'h1E, 0);
    check("note7_gate", voice_gate, 4'b0001);
    check("note7_value", voice_note[5:0], 7);
    send(8'h1C, 0);
    check("note7_off", voice_gate, 4'b0000);
    // Repeat note-on yields retrigger.
    send(8'h1E, 0);
    send(8'h1E, 0);
    check("retrig_gate", voice_gate, 4'b0001);

    // Fill the table then exceed it.
    do_reset();
    send(8'h06, 0);
    send(8'h0A, 0);
    send(8'h0E, 0);
    send(8'h12, 0);
    send(8'h26, 0);
    check("full_gate", voice_gate, 4'b1111);
    send(8'h2E, 0);

    // Unmatched note-off with mstart held through the scan.
    send(8'h28, 1);
    send(8'h29, 1);

    // Reset in the middle of a scan.
    do_reset();
    @(negedge clk);
    data = 8'h1E;
    mstart = 1'b1;
    @(posedge clk); #1;
    mstart = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("midscan_mready", mready, 0);
    check("midscan_pulses", {prog_strobe, retrig, overflow}, 0);
    check("midscan_outputs", {voice_note, voice_gate, program_num}, 0);
    model_clear();
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    check("midscan_release_mready", mready, 1);
    repeat (8) @(posedge clk);
    #1;
    check_outputs("midscan_after");

    // Randomized traffic over a small note range so hits and full tables occur.
    for (int i = 0; i < 300; i++) begin
      logic [7:0] b;
      int kind = $urandom_range(0, 3);
      logic [5:0] nn = 6'($urandom_range(0, 6));
      case (kind)
        0:       b = {7'($urandom), 1'b1};
        1:       b = {nn, 2'b00};
        default: b = {nn, 2'b10};
      endcase
      send(b, bit'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
